// File: rtl/pixel_input_pkg.sv
// Shared definitions for the pixel cursor input stage: button indices, key FSM states,
// and the helper used to size every timing counter from the largest configured count.
package pixel_input_pkg;

    localparam int NUM_BTN   = 4;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_LEFT  = 3;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_HELD   = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, then a level filter that accepts a new value only after
// it has differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronized input agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced buttons -> single-cycle cursor step pulses, priority up > down > right > left.
// Auto-repeat only when PIXEL_KEY_AUTOREPEAT_EN is defined; press-to-pulse latency DEBOUNCE_CYCLES + 4.
module key_pulse_gen
    import pixel_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               up,
    output logic               down,
    output logic               right,
    output logic               left,
    output logic [NUM_BTN-1:0] btn_level
);

    // One width shared by every timing counter so none can be too narrow for its limit.
    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk_i  (CLOCK_50),
            .rst_n_i(reset),
            .raw_i  (btn_raw[g]),
            .level_o(btn_level[g])
        );
    end

    key_state_e         state_q [NUM_BTN];
    key_state_e         state_d [NUM_BTN];
    logic [NUM_BTN-1:0] req_q;
    logic [NUM_BTN-1:0] req_d;
    logic [NUM_BTN-1:0] pulse_q;
    logic [NUM_BTN-1:0] pulse_d;

`ifdef PIXEL_KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [CNT_W-1:0] rpt_cnt_q [NUM_BTN];
    logic [CNT_W-1:0] rpt_cnt_d [NUM_BTN];
`endif

    // IDLE means the level was 0 last cycle, so IDLE->HELD is exactly the 0->1 edge.
    always_comb begin
        for (int b = 0; b < NUM_BTN; b++) begin
            state_d[b] = state_q[b];
            req_d[b]   = 1'b0;
`ifdef PIXEL_KEY_AUTOREPEAT_EN
            rpt_cnt_d[b] = rpt_cnt_q[b];
`endif
            if (!btn_level[b]) begin
                state_d[b] = KEY_IDLE;
            end else begin
                case (state_q[b])
                    KEY_IDLE: begin
                        state_d[b] = KEY_HELD;
                        req_d[b]   = 1'b1;
`ifdef PIXEL_KEY_AUTOREPEAT_EN
                        rpt_cnt_d[b] = '0;
`endif
                    end
                    KEY_HELD: begin
`ifdef PIXEL_KEY_AUTOREPEAT_EN
                        if (rpt_cnt_q[b] >= DELAY_LAST) begin
                            state_d[b]   = KEY_REPEAT;
                            req_d[b]     = 1'b1;
                            rpt_cnt_d[b] = '0;
                        end else if (rpt_cnt_q[b] != CNT_MAX) begin
                            rpt_cnt_d[b] = rpt_cnt_q[b] + CNT_W'(1);
                        end
`else
                        state_d[b] = KEY_HELD;
`endif
                    end
                    KEY_REPEAT: begin
`ifdef PIXEL_KEY_AUTOREPEAT_EN
                        if (rpt_cnt_q[b] >= PERIOD_LAST) begin
                            req_d[b]     = 1'b1;
                            rpt_cnt_d[b] = '0;
                        end else if (rpt_cnt_q[b] != CNT_MAX) begin
                            rpt_cnt_d[b] = rpt_cnt_q[b] + CNT_W'(1);
                        end
`else
                        state_d[b] = KEY_HELD;
`endif
                    end
                    default: state_d[b] = KEY_IDLE;
                endcase
            end
        end
    end

    // Walk from lowest priority upward so the highest-priority request wins; losers are dropped.
    always_comb begin
        pulse_d = '0;
        for (int b = NUM_BTN - 1; b >= 0; b--) begin
            if (req_q[b]) begin
                pulse_d    = '0;
                pulse_d[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BTN; b++) begin
                state_q[b] <= KEY_IDLE;
`ifdef PIXEL_KEY_AUTOREPEAT_EN
                rpt_cnt_q[b] <= '0;
`endif
            end
            req_q   <= '0;
            pulse_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BTN; b++) begin
                state_q[b] <= state_d[b];
`ifdef PIXEL_KEY_AUTOREPEAT_EN
                rpt_cnt_q[b] <= rpt_cnt_d[b];
`endif
            end
            req_q   <= req_d;
            pulse_q <= pulse_d;
        end
    end

    assign up    = pulse_q[BTN_UP];
    assign down  = pulse_q[BTN_DOWN];
    assign right = pulse_q[BTN_RIGHT];
    assign left  = pulse_q[BTN_LEFT];

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles (10 ms at 50 MHz) before a button level is accepted.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, cycles a button is held after its press pulse before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between auto-repeat pulses.
REQ-004 SHALL have port CLOCK_50  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port btn_raw  input  4  asynchronous active-high buttons, bit0 up, bit1 down, bit2 right, bit3 left.
REQ-007 SHALL have ports up, down, right, left  output  1 each  registered single-cycle step pulses for the cursor-position stage.
REQ-008 SHALL have port btn_level  output  4  debounced button levels, same bit order as btn_raw.

Function
REQ-009 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-010 SHALL, per bit, copy the synchronized value to btn_level only after it has differed from btn_level for DEBOUNCE_CYCLES consecutive cycles; any return to equality resets that bit's counter to 0.
REQ-011 SHALL raise a per-bit request in the cycle after btn_level for that bit goes 0->1; a 1->0 transition produces no request.
REQ-012 SHALL give each bit an FSM: IDLE (level 0), HELD (level 1, counting REPEAT_DELAY), REPEAT (level 1, counting REPEAT_PERIOD); a level drop returns it to IDLE from any state in the next cycle.
REQ-013 SHALL assert at most one of up/down/right/left per cycle, priority up > down > right > left.
REQ-014 SHALL drop lower-priority requests that lose arbitration in the same cycle; they are not queued.
REQ-015 SHALL keep each output pulse exactly one cycle wide; a held button without auto-repeat yields exactly one pulse.
REQ-016 SHALL size counters to $clog2(max parameter + 1) bits; counters saturate, never wrap.
REQ-017 SHALL have total latency from a stable btn_raw edge to the output pulse of DEBOUNCE_CYCLES + 4 cycles (2 sync, 1 accept, 1 output register).

Reset
REQ-018 SHALL, while reset == 0 at a clock edge, clear synchronizers, counters, btn_level, and all four pulse outputs to 0, and force every FSM to IDLE.
REQ-019 SHALL, after reset deassertion with a button already held, require the full DEBOUNCE_CYCLES before btn_level sets and then emit one press pulse.
REQ-020 SHALL, if reset asserts mid-debounce or mid-repeat, discard all progress with no pulse emitted.

Configuration
REQ-021 SHALL compile auto-repeat in only when macro PIXEL_KEY_AUTOREPEAT_EN is defined.
REQ-022 SHALL, with PIXEL_KEY_AUTOREPEAT_EN, move HELD->REPEAT after REPEAT_DELAY cycles with one request on entry, then one request every REPEAT_PERIOD cycles while the level stays 1.
REQ-023 SHALL, without PIXEL_KEY_AUTOREPEAT_EN, omit HELD/REPEAT counters; the FSM holds in HELD until release, and REPEAT_DELAY/REPEAT_PERIOD are ignored.

Structure
REQ-024 SHALL place in shared package pixel_input_pkg: the button index constants (BTN_UP=0, BTN_DOWN=1, BTN_RIGHT=2, BTN_LEFT=3), the FSM state enum key_state_e, and NUM_BTN=4.
REQ-025 SHALL implement synchronizer plus debounce counter as sub-module key_debounce, instantiated once per button; FSM and arbitration stay in key_pulse_gen.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 SHALL cover a clean press: btn_raw[0] 0->1 held 20 cycles -> up high exactly 1 cycle, 8 cycles after the edge; no other output.
REQ-027 SHALL cover bounce: btn_raw[2] toggled every 2 cycles for 12 cycles then 0 -> btn_level[2] stays 0, right never asserts.
REQ-028 SHALL cover a simultaneous press: btn_raw = 4'b1001 in one cycle -> single up pulse only; left pulse dropped.
REQ-029 SHALL cover auto-repeat, macro defined: btn_raw[3] held 30 cycles -> left pulses at press, +10, +13, +16, ... until release.
REQ-030 SHALL cover no-repeat build: same stimulus as REQ-029 -> exactly one left pulse.
REQ-031 SHALL cover reset mid-operation: reset=0 for 1 cycle while button held in REPEAT -> all outputs 0 next cycle, then a fresh press pulse 4+4 cycles after reset release.
